// File: rtl/cp0_pkg.sv
// Shared CP0 definitions: register addresses, Status/Cause bit positions, reset values
// and helpers that assemble the architectural Status/Cause words.
package cp0_pkg;

  localparam logic [7:0] CP0_ADDR_COUNT   = 8'h48;
  localparam logic [7:0] CP0_ADDR_COMPARE = 8'h58;
  localparam logic [7:0] CP0_ADDR_STATUS  = 8'h60;
  localparam logic [7:0] CP0_ADDR_CAUSE   = 8'h68;

  localparam int unsigned ST_IE  = 0;
  localparam int unsigned ST_EXL = 1;
  localparam int unsigned ST_IM  = 8;
  localparam int unsigned ST_BEV = 22;

  localparam int unsigned CA_EXCCODE = 2;
  localparam int unsigned CA_IP      = 8;
  localparam int unsigned CA_TI      = 30;
  localparam int unsigned CA_BD      = 31;

  localparam logic [31:0] STATUS_RST = 32'h0040_0000;
  localparam logic [31:0] CAUSE_RST  = 32'h0000_0000;

  // Bev is hard-wired; every field not passed in reads as zero.
  function automatic logic [31:0] pack_status(input logic [7:0] im,
                                              input logic       exl,
                                              input logic       ie);
    logic [31:0] s;
    s             = STATUS_RST;
    s[ST_BEV]     = 1'b1;
    s[ST_IM +: 8] = im;
    s[ST_EXL]     = exl;
    s[ST_IE]      = ie;
    return s;
  endfunction

  function automatic logic [31:0] pack_cause(input logic       bd,
                                             input logic       ti,
                                             input logic [7:0] ip,
                                             input logic [4:0] exccode);
    logic [31:0] c;
    c                  = CAUSE_RST;
    c[CA_BD]           = bd;
    c[CA_TI]           = ti;
    c[CA_IP +: 8]      = ip;
    c[CA_EXCCODE +: 5] = exccode;
    return c;
  endfunction

endpackage

// File: rtl/cp0_timer.sv
// Count/Compare timer: prescaled Count, Compare register and the sticky timer interrupt TI.
// Only instantiated when CP0_TIMER_EN is defined.
module cp0_timer
  import cp0_pkg::*;
#(
  parameter int unsigned COUNT_DIV = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        count_we,
  input  logic        compare_we,
  input  logic [31:0] wdata,
  output logic [31:0] count_o,
  output logic [31:0] compare_o,
  output logic        ti_o
);

  localparam int unsigned DIV_W = (COUNT_DIV > 1) ? $clog2(COUNT_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(COUNT_DIV - 1);

  logic [DIV_W-1:0] div_q, div_d;
  logic [31:0]      count_q, count_d;
  logic [31:0]      compare_q, compare_d;
  logic             ti_q, ti_d;
  logic             tick_s;
  logic [31:0]      count_inc_s;

  assign tick_s      = (div_q == DIV_LAST);
  assign count_inc_s = count_q + 32'd1;

  // Next-state for prescaler, Count, Compare and TI.
  always_comb begin
    div_d     = div_q;
    count_d   = count_q;
    compare_d = compare_q;
    ti_d      = ti_q;
    if (count_we) begin
      // A software load restarts the prescale period and skips the match test.
      count_d = wdata;
      div_d   = '0;
    end else if (tick_s) begin
      div_d   = '0;
      count_d = count_inc_s;
      if (count_inc_s == compare_q) begin
        ti_d = 1'b1;
      end else begin
        ti_d = ti_q;
      end
    end else begin
      div_d = div_q + DIV_W'(1);
    end
    if (compare_we) begin
      compare_d = wdata;
      ti_d      = 1'b0;
    end else begin
      compare_d = compare_q;
    end
  end

  // Timer state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_q     <= '0;
      count_q   <= 32'd0;
      compare_q <= 32'd0;
      ti_q      <= 1'b0;
    end else begin
      div_q     <= div_d;
      count_q   <= count_d;
      compare_q <= compare_d;
      ti_q      <= ti_d;
    end
  end

  assign count_o   = count_q;
  assign compare_o = compare_q;
  assign ti_o      = ti_q;

endmodule

// File: rtl/cp0_int_ctrl.sv
// CP0 Status/Cause holder with synchronised hw interrupts, sw interrupts and interrupt request.
// Define CP0_TIMER_EN to include the Count/Compare timer (cp0_timer).
module cp0_int_ctrl
  import cp0_pkg::*;
#(
  parameter int unsigned HW_INT_W  = 6,
  parameter int unsigned SYNC_STG  = 2,
  parameter int unsigned COUNT_DIV = 2
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                mtc0_we,
  input  logic [7:0]          cp0_addr,
  input  logic [31:0]         mtc0_data,
  input  logic                exception,
  input  logic [4:0]          exc_code,
  input  logic                exc_bd,
  input  logic                eret_op,
  input  logic [HW_INT_W-1:0] hw_int,
  output logic [31:0]         status_o,
  output logic [31:0]         cause_o,
  output logic [31:0]         count_o,
  output logic [31:0]         compare_o,
  output logic                int_req
);

  logic [HW_INT_W-1:0] sync_q [SYNC_STG];
  logic [HW_INT_W-1:0] sync_d [SYNC_STG];
  logic [HW_INT_W-1:0] hw_sync_s;
  logic [5:0]          hw_pad_s;

  logic [7:0] im_q, im_d;
  logic       ie_q, ie_d;
  logic       exl_q, exl_d;
  logic       bd_q, bd_d;
  logic [4:0] exccode_q, exccode_d;
  logic [1:0] ip_sw_q, ip_sw_d;
  logic       int_req_q, int_req_d;

  logic [7:0]  ip_s;
  logic        ti_s;
  logic [31:0] count_s;
  logic [31:0] compare_s;
  logic        wr_status_s;
  logic        wr_cause_s;
  logic        unused_data_s;

  assign wr_status_s   = mtc0_we && (cp0_addr == CP0_ADDR_STATUS);
  assign wr_cause_s    = mtc0_we && (cp0_addr == CP0_ADDR_CAUSE);
  assign unused_data_s = ^{mtc0_data[31:16], mtc0_data[7:2]};

  // Shift chain feeding each hw_int line through SYNC_STG flops.
  always_comb begin
    sync_d[0] = hw_int;
    for (int i = 1; i < int'(SYNC_STG); i++) begin
      sync_d[i] = sync_q[i-1];
    end
  end

  // Synchroniser flops.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(SYNC_STG); i++) begin
        sync_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < int'(SYNC_STG); i++) begin
        sync_q[i] <= sync_d[i];
      end
    end
  end

  assign hw_sync_s = sync_q[SYNC_STG-1];
  // Zero-extend so lines beyond HW_INT_W read as 0; line 5 shares IP7 with TI.
  assign hw_pad_s  = 6'(hw_sync_s);
  assign ip_s      = {hw_pad_s[5] | ti_s, hw_pad_s[4:0], ip_sw_q};

`ifdef CP0_TIMER_EN
  logic wr_count_s;
  logic wr_compare_s;

  assign wr_count_s   = mtc0_we && (cp0_addr == CP0_ADDR_COUNT);
  assign wr_compare_s = mtc0_we && (cp0_addr == CP0_ADDR_COMPARE);

  cp0_timer #(
    .COUNT_DIV (COUNT_DIV)
  ) u_timer (
    .clk        (clk),
    .rst_n      (rst_n),
    .count_we   (wr_count_s),
    .compare_we (wr_compare_s),
    .wdata      (mtc0_data),
    .count_o    (count_s),
    .compare_o  (compare_s),
    .ti_o       (ti_s)
  );
`else
  assign count_s   = 32'd0;
  assign compare_s = 32'd0;
  assign ti_s      = 1'b0;
`endif

  // Status/Cause next state; EXL priority is exception > ERET > MTC0.
  always_comb begin
    im_d      = im_q;
    ie_d      = ie_q;
    exl_d     = exl_q;
    bd_d      = bd_q;
    exccode_d = exccode_q;
    ip_sw_d   = ip_sw_q;

    if (wr_status_s) begin
      im_d  = mtc0_data[ST_IM +: 8];
      ie_d  = mtc0_data[ST_IE];
      exl_d = mtc0_data[ST_EXL];
    end else begin
      im_d = im_q;
    end

    if (exception) begin
      exl_d     = 1'b1;
      bd_d      = exc_bd;
      exccode_d = exc_code;
    end else if (eret_op) begin
      exl_d = 1'b0;
    end else begin
      bd_d = bd_q;
    end

    if (wr_cause_s) begin
      ip_sw_d = mtc0_data[CA_IP +: 2];
    end else begin
      ip_sw_d = ip_sw_q;
    end

    // Masked the cycle after an exception because EXL is being set on this edge.
    if (exception) begin
      int_req_d = 1'b0;
    end else begin
      int_req_d = ie_q & ~exl_q & (|(ip_s & im_q));
    end
  end

  // Status, Cause and interrupt-request registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      im_q      <= 8'h00;
      ie_q      <= 1'b0;
      exl_q     <= 1'b0;
      bd_q      <= 1'b0;
      exccode_q <= 5'd0;
      ip_sw_q   <= 2'b00;
      int_req_q <= 1'b0;
    end else begin
      im_q      <= im_d;
      ie_q      <= ie_d;
      exl_q     <= exl_d;
      bd_q      <= bd_d;
      exccode_q <= exccode_d;
      ip_sw_q   <= ip_sw_d;
      int_req_q <= int_req_d;
    end
  end

  assign status_o  = pack_status(im_q, exl_q, ie_q);
  assign cause_o   = pack_cause(bd_q, ti_s, ip_s, exccode_q);
  assign count_o   = count_s;
  assign compare_o = compare_s;
  assign int_req   = int_req_q;

endmodule

// File: tb/tb_cp0_int_ctrl.sv
// Self-checking bench for cp0_int_ctrl: directed steps plus randomised traffic against a
// behavioural model; timer checks follow CP0_TIMER_EN.
module tb_cp0_int_ctrl;

  localparam int HW = 6;
  localparam int SS = 2;
  localparam int CD = 2;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          mtc0_we;
  logic [7:0]    cp0_addr;
  logic [31:0]   mtc0_data;
  logic          exception;
  logic [4:0]    exc_code;
  logic          exc_bd;
  logic          eret_op;
  logic [HW-1:0] hw_int;
  logic [31:0]   status_o, cause_o, count_o, compare_o;
  logic          int_req;

  int tests = 0;
  int fails = 0;

  // Reference state, kept as architectural fields rather than flops.
  logic [7:0]    m_im;
  logic          m_ie, m_exl, m_bd, m_ti, m_intreq;
  logic [4:0]    m_exc;
  logic [1:0]    m_sw;
  logic [31:0]   m_load, m_cmp;
  longint        m_edges;
  logic [HW-1:0] m_hist[$];

  cp0_int_ctrl #(.HW_INT_W(HW), .SYNC_STG(SS), .COUNT_DIV(CD)) dut (
    .clk(clk), .rst_n(rst_n), .mtc0_we(mtc0_we), .cp0_addr(cp0_addr), .mtc0_data(mtc0_data),
    .exception(exception), .exc_code(exc_code), .exc_bd(exc_bd), .eret_op(eret_op),
    .hw_int(hw_int), .status_o(status_o), .cause_o(cause_o), .count_o(count_o),
    .compare_o(compare_o), .int_req(int_req)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] exp_ip();
    logic [5:0] hw6;
    hw6 = 6'(m_hist[0]);
    return {hw6[5] | m_ti, hw6[4:0], m_sw};
  endfunction

  function automatic logic [31:0] exp_status();
    return 32'h0040_0000 | {16'h0000, m_im, 6'b000000, m_exl, m_ie};
  endfunction

  function automatic logic [31:0] exp_cause();
    return {m_bd, m_ti, 14'h0000, exp_ip(), 1'b0, m_exc, 2'b00};
  endfunction

  function automatic logic [31:0] exp_count();
`ifdef CP0_TIMER_EN
    return m_load + 32'(m_edges / CD);
`else
    return 32'd0;
`endif
  endfunction

  function automatic logic [31:0] exp_compare();
`ifdef CP0_TIMER_EN
    return m_cmp;
`else
    return 32'd0;
`endif
  endfunction

  task automatic model_reset();
    m_im = 8'h00; m_ie = 1'b0; m_exl = 1'b0; m_bd = 1'b0; m_ti = 1'b0; m_intreq = 1'b0;
    m_exc = 5'd0; m_sw = 2'b00; m_load = 32'd0; m_cmp = 32'd0; m_edges = 0;
    m_hist.delete();
    for (int i = 0; i < SS; i++) m_hist.push_back('0);
  endtask

  // Apply one clock edge worth of architectural rules using the inputs now on the pins.
  task automatic model_edge();
    logic        nreq;
    logic [31:0] newc;
    nreq = exception ? 1'b0 : (m_ie & ~m_exl & (|(exp_ip() & m_im)));
    if (mtc0_we && cp0_addr == 8'h60) begin
      m_im = mtc0_data[15:8]; m_ie = mtc0_data[0]; m_exl = mtc0_data[1];
    end
    if (eret_op) m_exl = 1'b0;
    if (exception) begin
      m_exl = 1'b1; m_bd = exc_bd; m_exc = exc_code;
    end
    if (mtc0_we && cp0_addr == 8'h68) m_sw = mtc0_data[9:8];
`ifdef CP0_TIMER_EN
    if (mtc0_we && cp0_addr == 8'h48) begin
      m_load = mtc0_data; m_edges = 0;
    end else begin
      m_edges++;
      if (m_edges % CD == 0) begin
        newc = m_load + 32'(m_edges / CD);
        if (newc == m_cmp) m_ti = 1'b1;
      end
    end
    if (mtc0_we && cp0_addr == 8'h58) begin
      m_cmp = mtc0_data; m_ti = 1'b0;
    end
`endif
    m_hist.push_back(hw_int);
    void'(m_hist.pop_front());
    m_intreq = nreq;
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".status"}, status_o, exp_status());
    chk({tag, ".cause"}, cause_o, exp_cause());
    chk({tag, ".count"}, count_o, exp_count());
    chk({tag, ".compare"}, compare_o, exp_compare());
    chk({tag, ".int_req"}, {31'd0, int_req}, {31'd0, m_intreq});
  endtask

  task automatic tick(input string tag);
    model_edge();
    @(posedge clk);
    #1;
    check_all(tag);
  endtask

  task automatic mtc0(input logic [7:0] a, input logic [31:0] d, input string tag);
    mtc0_we = 1'b1; cp0_addr = a; mtc0_data = d;
    tick(tag);
    mtc0_we = 1'b0;
  endtask

  initial begin
    logic [7:0] addr_tbl [5];
    rst_n = 1'b0; mtc0_we = 1'b0; cp0_addr = 8'h00; mtc0_data = 32'd0;
    exception = 1'b0; exc_code = 5'd0; exc_bd = 1'b0; eret_op = 1'b0; hw_int = '0;
    model_reset();
    #12;
    check_all("reset");
    chk("reset.status_const", status_o, 32'h0040_0000);
    rst_n = 1'b1;

    // hw_int[0] path: IP2 visible two edges after sampling, request one edge later.
    mtc0(8'h60, 32'h0000_0401, "wr_status");
    hw_int = 6'b000001;
    tick("hw0_a");
    tick("hw0_b");
    chk("hw0.ip2", {31'd0, cause_o[10]}, 32'd1);
    chk("hw0.req_early", {31'd0, int_req}, 32'd0);
    tick("hw0_c");
    chk("hw0.req", {31'd0, int_req}, 32'd1);
    exception = 1'b1; exc_code = 5'h00;
    tick("exc");
    exception = 1'b0;
    chk("exc.req_masked", {31'd0, int_req}, 32'd0);
    chk("exc.exl", {31'd0, status_o[1]}, 32'd1);

    // Exception and ERET together: set wins.
    exception = 1'b1; eret_op = 1'b1; exc_code = 5'h04; exc_bd = 1'b1;
    tick("exc_eret");
    exception = 1'b0; eret_op = 1'b0; exc_bd = 1'b0;
    chk("exc_eret.exl", {31'd0, status_o[1]}, 32'd1);
    chk("exc_eret.bd", {31'd0, cause_o[31]}, 32'd1);
    chk("exc_eret.code", {27'd0, cause_o[6:2]}, 32'd4);
    eret_op = 1'b1;
    tick("eret");
    eret_op = 1'b0;
    chk("eret.exl", {31'd0, status_o[1]}, 32'd0);
    mtc0(8'h68, 32'h0000_0300, "wr_cause_sw");
    mtc0(8'h70, 32'hFFFF_FFFF, "wr_unmapped");

`ifdef CP0_TIMER_EN
    mtc0(8'h58, 32'd3, "wr_cmp3");
    mtc0(8'h48, 32'd0, "wr_cnt0");
    for (int i = 0; i < 5; i++) tick("ti_wait");
    chk("ti.before", {31'd0, cause_o[30]}, 32'd0);
    tick("ti_set");
    chk("ti.set", {31'd0, cause_o[30]}, 32'd1);
    chk("ti.count", count_o, 32'd3);
    mtc0(8'h58, 32'd10, "wr_cmp10");
    chk("ti.clear", {31'd0, cause_o[30]}, 32'd0);
    mtc0(8'h58, 32'd0, "wr_cmp0");
    mtc0(8'h48, 32'hFFFF_FFFF, "wr_cnt_max");
    tick("wrap_a");
    tick("wrap_b");
    chk("wrap.count", count_o, 32'd0);
    chk("wrap.ti", {31'd0, cause_o[30]}, 32'd1);
    mtc0(8'h58, 32'd4, "wr_cmp4");
    mtc0(8'h48, 32'd3, "wr_cnt3");
    tick("sup_a");
    mtc0(8'h48, 32'd3, "wr_cnt_on_match");
    chk("sup.ti", {31'd0, cause_o[30]}, 32'd0);
    chk("sup.count", count_o, 32'd3);
`else
    mtc0(8'h48, 32'd5, "wr_cnt_off");
    chk("notimer.count", count_o, 32'd0);
    mtc0(8'h58, 32'd5, "wr_cmp_off");
    chk("notimer.compare", compare_o, 32'd0);
`endif
    hw_int = 6'b100000;
    tick("hw5_a");
    tick("hw5_b");
    chk("hw5.ip7", {31'd0, cause_o[15]}, 32'd1);

    // Randomised traffic.
    addr_tbl[0] = 8'h48; addr_tbl[1] = 8'h58; addr_tbl[2] = 8'h60; addr_tbl[3] = 8'h68;
    for (int n = 0; n < 600; n++) begin
      addr_tbl[4] = 8'($urandom);
      mtc0_we   = ($urandom_range(0, 3) == 0);
      cp0_addr  = addr_tbl[$urandom_range(0, 4)];
      mtc0_data = ($urandom_range(0, 1) == 1) ? $urandom : exp_count() + 32'($urandom_range(0, 3));
      exception = ($urandom_range(0, 15) == 0);
      eret_op   = ($urandom_range(0, 9) == 0);
      exc_code  = 5'($urandom);
      exc_bd    = 1'($urandom);
      if ($urandom_range(0, 3) == 0) hw_int = HW'($urandom);
      tick("rand");
    end
    mtc0_we = 1'b0; exception = 1'b0; eret_op = 1'b0;

    // Asynchronous reset between clock edges.
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    chk("arst.status", status_o, 32'h0040_0000);
    chk("arst.cause", cause_o, 32'd0);
    chk("arst.int_req", {31'd0, int_req}, 32'd0);
    chk("arst.count", count_o, 32'd0);
    #1;
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) tick("post_rst");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
